fast_divider: RTL and testbench

Single-cycle unsigned integer divider ("fast" division, in contrast to the iterative slow divider). Uses a fully unrolled non-restoring array: WIDTH combinational add/subtract rows, with the quotient and remainder registered once per clock. Sits in the arithmetic datapath and accepts a new operand pair every cycle.

---
 rtl/fast_div_pkg.sv | 19 +
 rtl/fast_div_row.sv | 26 ++
 rtl/fast_divider.sv | 71 +++++++
 tb/tb_fast_divider.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_div_pkg.sv
// Shared constants and helpers for the single-cycle array divider.
package fast_div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 64;

    // All-ones quotient reported for a zero divisor, sized by the caller.
    function automatic logic [MAX_WIDTH-1:0] dbz_quotient(input int unsigned width);
        logic [MAX_WIDTH-1:0] q;
        q = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                q[i] = 1'b1;
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/fast_div_row.sv
// One non-restoring row: shift in a dividend bit, then add or subtract the divisor.
module fast_div_row #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH:0]   prem,
    input  logic             dbit,
    input  logic [WIDTH-1:0] divisor,
    input  logic             sub,
    output logic [WIDTH:0]   prem_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted;

    // Arithmetic wraps at WIDTH+1 bits; the true result always fits, so the wrap is harmless.
    always_comb begin
        shifted = (prem << 1) | (WIDTH+1)'(dbit);
        if (sub) begin
            prem_next = shifted - {1'b0, divisor};
        end else begin
            prem_next = shifted + {1'b0, divisor};
        end
        qbit = ~prem_next[WIDTH];
    end

endmodule

// File: rtl/fast_divider.sv
// Single-cycle unsigned divider: unrolled non-restoring row chain plus one output register.
module fast_divider
    import fast_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] DBZ_QUOTIENT = WIDTH'(dbz_quotient(WIDTH));

    logic [WIDTH:0]   prem [WIDTH+1];
    logic [WIDTH-1:0] q_c;
    logic [WIDTH-1:0] rem_c;
    logic             dbz_c;

    assign prem[0] = '0;

    // Row i consumes dividend bit WIDTH-1-i; a non-negative previous remainder selects subtract.
    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        fast_div_row #(
            .WIDTH(WIDTH)
        ) u_row (
            .prem      (prem[i]),
            .dbit      (dividend[WIDTH-1-i]),
            .divisor   (divisor),
            .sub       (~prem[i][WIDTH]),
            .prem_next (prem[i+1]),
            .qbit      (q_c[WIDTH-1-i])
        );
    end

    // A negative final partial remainder is restored by adding the divisor back.
    always_comb begin
        rem_c = prem[WIDTH][WIDTH-1:0];
        if (prem[WIDTH][WIDTH]) begin
            rem_c = prem[WIDTH][WIDTH-1:0] + divisor;
        end
        dbz_c = (divisor == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                div_by_zero <= dbz_c;
                if (dbz_c) begin
                    quotient  <= DBZ_QUOTIENT;
                    remainder <= dividend;
                end else begin
                    quotient  <= q_c;
                    remainder <= rem_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_fast_divider.sv
// Self-checking bench for fast_divider at WIDTH 4 (exhaustive) and WIDTH 8 (random).
module tb_fast_divider;

    localparam int unsigned W  = 4;
    localparam int unsigned W8 = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          out_valid;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    logic          in_valid8;
    logic [W8-1:0] dividend8;
    logic [W8-1:0] divisor8;
    logic          out_valid8;
    logic [W8-1:0] quotient8;
    logic [W8-1:0] remainder8;
    logic          div_by_zero8;

    int checks;
    int errors;

    fast_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    fast_divider #(.WIDTH(W8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid8),
        .dividend    (dividend8),
        .divisor     (divisor8),
        .out_valid   (out_valid8),
        .quotient    (quotient8),
        .remainder   (remainder8),
        .div_by_zero (div_by_zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer division, zero divisor yields all ones / dividend.
    function automatic int model_q(input int a, input int b, input int w);
        if (b == 0) return (1 << w) - 1;
        return a / b;
    endfunction

    function automatic int model_r(input int a, input int b);
        if (b == 0) return a;
        return a % b;
    endfunction

    // Present operands, let one rising edge sample them, then settle past the edge.
    task automatic step(input int a, input int b, input logic v);
        dividend = W'(a);
        divisor  = W'(b);
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(0, 0, 1'b0);
        step(0, 0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b q=%0d r=%0d z=%b, need v=0 q=0 r=0 z=0",
                     out_valid, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        step(0, 0, 1'b0);
    endtask

    task automatic test_basic;
        int a_tab [3] = '{10, 12, 11};
        int b_tab [3] = '{2, 4, 5};
        for (int i = 0; i < 3; i++) begin
            step(a_tab[i], b_tab[i], 1'b1);
            checks++;
            if (out_valid !== 1'b1 || div_by_zero !== 1'b0 ||
                int'(quotient) !== model_q(a_tab[i], b_tab[i], W) ||
                int'(remainder) !== model_r(a_tab[i], b_tab[i])) begin
                errors++;
                $display("FAIL basic %0d/%0d: got v=%b q=%0d r=%0d z=%b, need v=1 q=%0d r=%0d z=0",
                         a_tab[i], b_tab[i], out_valid, quotient, remainder, div_by_zero,
                         model_q(a_tab[i], b_tab[i], W), model_r(a_tab[i], b_tab[i]));
            end
            step(0, 0, 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_pulse %0d/%0d: got out_valid=%b, need 0", a_tab[i], b_tab[i], out_valid);
            end
        end
    endtask

    task automatic test_edges;
        int a_tab [4] = '{3, 15, 15, 0};
        int b_tab [4] = '{7, 1, 15, 9};
        int q_tab [4] = '{0, 15, 1, 0};
        int r_tab [4] = '{3, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            step(a_tab[i], b_tab[i], 1'b1);
            checks++;
            if (out_valid !== 1'b1 || div_by_zero !== 1'b0 ||
                int'(quotient) !== q_tab[i] || int'(remainder) !== r_tab[i]) begin
                errors++;
                $display("FAIL edge %0d/%0d: got v=%b q=%0d r=%0d z=%b, need v=1 q=%0d r=%0d z=0",
                         a_tab[i], b_tab[i], out_valid, quotient, remainder, div_by_zero,
                         q_tab[i], r_tab[i]);
            end
        end
        step(0, 0, 1'b0);
    endtask

    task automatic test_div_zero;
        step(7, 0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || quotient !== 4'd15 || remainder !== 4'd7 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div_zero 7/0: got v=%b q=%0d r=%0d z=%b, need v=1 q=15 r=7 z=1",
                     out_valid, quotient, remainder, div_by_zero);
        end
        step(8, 3, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || quotient !== 4'd2 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL after_zero 8/3: got v=%b q=%0d r=%0d z=%b, need v=1 q=2 r=2 z=0",
                     out_valid, quotient, remainder, div_by_zero);
        end
    endtask

    // Idle cycles hold the last result even while operands wander.
    task automatic test_hold;
        step(13, 6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(int'($urandom_range(15)), int'($urandom_range(15)), 1'b0);
            checks++;
            if (out_valid !== 1'b0 || quotient !== 4'd2 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: got v=%b q=%0d r=%0d z=%b, need v=0 q=2 r=1 z=0",
                         i, out_valid, quotient, remainder, div_by_zero);
            end
        end
    endtask

    task automatic test_back_to_back;
        int a_tab [3] = '{10, 12, 11};
        int b_tab [3] = '{2, 4, 5};
        int q_tab [3] = '{5, 3, 2};
        int r_tab [3] = '{0, 0, 1};
        for (int i = 0; i < 3; i++) begin
            step(a_tab[i], b_tab[i], 1'b1);
            checks++;
            if (out_valid !== 1'b1 || int'(quotient) !== q_tab[i] || int'(remainder) !== r_tab[i]) begin
                errors++;
                $display("FAIL back_to_back %0d/%0d: got v=%b q=%0d r=%0d, need v=1 q=%0d r=%0d",
                         a_tab[i], b_tab[i], out_valid, quotient, remainder, q_tab[i], r_tab[i]);
            end
        end
        step(0, 0, 1'b0);
    endtask

    task automatic test_reset_mid;
        rst = 1'b1;
        step(9, 2, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: got v=%b q=%0d r=%0d z=%b, need v=0 q=0 r=0 z=0",
                     out_valid, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        step(9, 2, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL after_reset 9/2: got v=%b q=%0d r=%0d z=%b, need v=1 q=4 r=1 z=0",
                     out_valid, quotient, remainder, div_by_zero);
        end
        step(0, 0, 1'b0);
    endtask

    task automatic test_exhaustive;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(a, b, 1'b1);
                checks++;
                if (out_valid !== 1'b1 || div_by_zero !== (b == 0) ||
                    int'(quotient) !== model_q(a, b, W) || int'(remainder) !== model_r(a, b)) begin
                    errors++;
                    $display("FAIL exhaustive %0d/%0d: got v=%b q=%0d r=%0d z=%b, need v=1 q=%0d r=%0d z=%b",
                             a, b, out_valid, quotient, remainder, div_by_zero,
                             model_q(a, b, W), model_r(a, b), (b == 0));
                end
            end
        end
        step(0, 0, 1'b0);
    endtask

    task automatic test_random_w8;
        int a;
        int b;
        for (int n = 0; n < 400; n++) begin
            a = int'($urandom_range(255));
            b = (n % 25 == 0) ? 0 : int'($urandom_range(255));
            dividend8 = W8'(a);
            divisor8  = W8'(b);
            in_valid8 = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid8 !== 1'b1 || div_by_zero8 !== (b == 0) ||
                int'(quotient8) !== model_q(a, b, W8) || int'(remainder8) !== model_r(a, b)) begin
                errors++;
                $display("FAIL random_w8 %0d/%0d: got v=%b q=%0d r=%0d z=%b, need v=1 q=%0d r=%0d z=%b",
                         a, b, out_valid8, quotient8, remainder8, div_by_zero8,
                         model_q(a, b, W8), model_r(a, b), (b == 0));
            end
        end
        in_valid8 = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        in_valid8 = 1'b0;
        dividend8 = '0;
        divisor8  = '0;

        test_reset;
        test_basic;
        test_edges;
        test_div_zero;
        test_hold;
        test_back_to_back;
        test_reset_mid;
        test_exhaustive;
        test_random_w8;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
